// File: rtl/regex_pc_scheduler_pkg.sv
// Shared types for the regex PC scheduler.
// FSM encoding and the CPU drain guard length.
package scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_CHAR,
    RUN,
    ADVANCE,
    DONE
  } state_e;

  localparam int unsigned GUARD_CYCLES = 2;

endpackage

// File: rtl/regex_pc_scheduler_fifo.sv
// Circular PC queue with clear-and-push support.
// A clear with push leaves exactly the pushed entry.
module regex_pc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [CW-1:0]    r_cnt;

  logic          w_push;
  logic          w_pop;
  logic          w_we;
  logic [AW-1:0] w_waddr;

  assign empty   = (r_cnt == '0);
  assign full    = (r_cnt == CW'(DEPTH));
  assign w_push  = push && !full;
  assign w_pop   = pop && !empty;
  assign w_we    = clear ? push : w_push;
  assign w_waddr = clear ? '0 : r_wp;
  assign head    = r_mem[r_rp];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (clear) begin
      r_rp  <= '0;
      r_wp  <= push ? AW'(1) : '0;
      r_cnt <= push ? CW'(1) : '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= push_data;
  end

endmodule

// File: rtl/regex_pc_scheduler.sv
// Thread scheduler around one regex_cpu: CUR/NXT PC queues,
// one character per step, accept/reject for the whole string.
module regex_pc_scheduler
  import scheduler_pkg::*;
#(
  parameter int PC_WIDTH        = 8,
  parameter int CHARACTER_WIDTH = 8,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_valid,
  output logic                       start_ready,
  input  logic [CHARACTER_WIDTH-1:0] char_in,
  input  logic                       char_in_last,
  input  logic                       char_in_valid,
  output logic                       char_in_ready,
  output logic [CHARACTER_WIDTH-1:0] current_character,
  output logic                       cpu_input_pc_valid,
  output logic [PC_WIDTH-1:0]        cpu_input_pc,
  input  logic                       cpu_input_pc_ready,
  input  logic                       cpu_output_pc_valid,
  input  logic [PC_WIDTH-1:0]        cpu_output_pc,
  input  logic                       cpu_output_pc_is_directed_to_current,
  output logic                       cpu_output_pc_ready,
  input  logic                       cpu_accepts,
  output logic                       done_valid,
  output logic                       done_accepted,
  input  logic                       done_ready,
  output logic                       overflow
);

  state_e r_state;
  state_e w_next;

  logic                       r_sel;
  logic                       r_last;
  logic                       r_acc;
  logic                       r_ovf;
  logic [1:0]                 r_guard;
  logic [CHARACTER_WIDTH-1:0] r_char;

  logic [1:0]          w_push;
  logic [1:0]          w_pop;
  logic [1:0]          w_empty;
  logic [1:0]          w_full;
  logic [PC_WIDTH-1:0] w_head [2];
  logic [PC_WIDTH-1:0] w_push_data;

  logic w_nsel;
  logic w_start;
  logic w_load;
  logic w_run;
  logic w_cur_empty;
  logic w_nxt_empty;
  logic w_disp;
  logic w_ret_cur;
  logic w_ret_nxt;
  logic w_drop;
  logic w_cpu_idle;

  assign w_nsel      = ~r_sel;
  assign w_run       = (r_state == RUN);
  assign w_start     = (r_state == IDLE) && start_valid;
  assign w_load      = (r_state == LOAD_CHAR) && char_in_valid;
  assign w_cur_empty = w_empty[r_sel];
  assign w_nxt_empty = w_empty[w_nsel];
  assign w_disp      = w_run && !w_cur_empty && cpu_input_pc_ready;

  assign w_ret_cur = w_run && cpu_output_pc_valid &&
                     cpu_output_pc_is_directed_to_current;
  assign w_ret_nxt = w_run && cpu_output_pc_valid &&
                     !cpu_output_pc_is_directed_to_current;

  assign w_drop = (w_ret_cur && w_full[r_sel]) ||
                  (w_ret_nxt && w_full[w_nsel]);

  // Guard covers PCs still inside the CPU pipeline after a dispatch.
  assign w_cpu_idle = cpu_input_pc_ready && !cpu_output_pc_valid &&
                      (r_guard == 2'd0);

  assign w_push_data = w_start ? '0 : cpu_output_pc;

  always_comb begin
    w_push = '0;
    w_pop  = '0;
    if (w_start)   w_push[r_sel]  = 1'b1;
    if (w_ret_cur) w_push[r_sel]  = 1'b1;
    if (w_ret_nxt) w_push[w_nsel] = 1'b1;
    if (w_disp)    w_pop[r_sel]   = 1'b1;
  end

  regex_pc_fifo #(
    .WIDTH (PC_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_q0 (
    .clk       (clk),
    .rst       (rst),
    .clear     (w_start),
    .push      (w_push[0]),
    .push_data (w_push_data),
    .pop       (w_pop[0]),
    .head      (w_head[0]),
    .empty     (w_empty[0]),
    .full      (w_full[0])
  );

  regex_pc_fifo #(
    .WIDTH (PC_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_q1 (
    .clk       (clk),
    .rst       (rst),
    .clear     (w_start),
    .push      (w_push[1]),
    .push_data (w_push_data),
    .pop       (w_pop[1]),
    .head      (w_head[1]),
    .empty     (w_empty[1]),
    .full      (w_full[1])
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:      if (start_valid)   w_next = LOAD_CHAR;
      LOAD_CHAR: if (char_in_valid) w_next = RUN;
      RUN: begin
        if (cpu_accepts) begin
          w_next = DONE;
        end else if (w_cur_empty && w_cpu_idle) begin
          if (r_last || w_nxt_empty) w_next = DONE;
          else                       w_next = ADVANCE;
        end
      end
      ADVANCE:   w_next = LOAD_CHAR;
      DONE:      if (done_ready)    w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_comb begin
    start_ready         = (r_state == IDLE);
    char_in_ready       = (r_state == LOAD_CHAR);
    cpu_input_pc_valid  = w_run && !w_cur_empty;
    cpu_input_pc        = cpu_input_pc_valid ? w_head[r_sel] : '0;
    cpu_output_pc_ready = w_run;
    done_valid          = (r_state == DONE);
    done_accepted       = (r_state == DONE) && r_acc;
    overflow            = r_ovf;
    current_character   = r_char;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel   <= 1'b0;
      r_last  <= 1'b0;
      r_acc   <= 1'b0;
      r_ovf   <= 1'b0;
      r_guard <= 2'd0;
      r_char  <= '0;
    end else begin
      if (w_start)     r_ovf <= 1'b0;
      else if (w_drop) r_ovf <= 1'b1;
      if (w_load) begin
        r_char <= char_in;
        r_last <= char_in_last;
      end
      if (w_disp)               r_guard <= 2'(GUARD_CYCLES);
      else if (r_guard != 2'd0) r_guard <= r_guard - 2'd1;
      if (r_state == ADVANCE)   r_sel <= ~r_sel;
      if (w_run && (w_next == DONE)) r_acc <= cpu_accepts;
    end
  end

endmodule

// File: tb/tb_regex_pc_scheduler.sv
// Randomized bench: behavioural CPU stub plus a queue-level
// model of the thread schedule for each match.
module tb_regex_pc_scheduler;

  localparam int PCW = 8;
  localparam int CHW = 8;
  localparam int D   = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           start_valid;
  logic           start_ready;
  logic [CHW-1:0] char_in;
  logic           char_in_last;
  logic           char_in_valid;
  logic           char_in_ready;
  logic [CHW-1:0] current_character;
  logic           cpu_input_pc_valid;
  logic [PCW-1:0] cpu_input_pc;
  logic           cpu_input_pc_ready;
  logic           cpu_output_pc_valid;
  logic [PCW-1:0] cpu_output_pc;
  logic           cpu_output_pc_is_directed_to_current;
  logic           cpu_output_pc_ready;
  logic           cpu_accepts;
  logic           done_valid;
  logic           done_accepted;
  logic           done_ready;
  logic           overflow;

  always #5 clk = ~clk;

  regex_pc_scheduler #(
    .PC_WIDTH        (PCW),
    .CHARACTER_WIDTH (CHW),
    .FIFO_DEPTH      (D)
  ) dut (
    .clk                                  (clk),
    .rst                                  (rst),
    .start_valid                          (start_valid),
    .start_ready                          (start_ready),
    .char_in                              (char_in),
    .char_in_last                         (char_in_last),
    .char_in_valid                        (char_in_valid),
    .char_in_ready                        (char_in_ready),
    .current_character                    (current_character),
    .cpu_input_pc_valid                   (cpu_input_pc_valid),
    .cpu_input_pc                         (cpu_input_pc),
    .cpu_input_pc_ready                   (cpu_input_pc_ready),
    .cpu_output_pc_valid                  (cpu_output_pc_valid),
    .cpu_output_pc                        (cpu_output_pc),
    .cpu_output_pc_is_directed_to_current (cpu_output_pc_is_directed_to_current),
    .cpu_output_pc_ready                  (cpu_output_pc_ready),
    .cpu_accepts                          (cpu_accepts),
    .done_valid                           (done_valid),
    .done_accepted                        (done_accepted),
    .done_ready                           (done_ready),
    .overflow                             (overflow)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // CPU program: per PC, outputs, acceptance, latency.
  int       p_nout  [8];
  logic [7:0] p_pc  [8][6];
  bit       p_dir   [8][6];
  bit       p_acc   [8];
  int       p_lat   [8];
  bit       p_merge [8];

  logic [7:0] s_ch [8];
  int         s_len = 0;
  int         s_gen = 0;
  int         feed_idx;

  int unsigned obs_pc [$];
  int unsigned obs_ch [$];
  int unsigned exp_pc [$];
  int unsigned exp_ch [$];
  bit          cpu_busy;

  // CPU stub: one PC in flight, outputs then optional accept.
  initial begin
    cpu_input_pc_ready = 1'b1;
    cpu_output_pc_valid = 1'b0;
    cpu_output_pc = '0;
    cpu_output_pc_is_directed_to_current = 1'b0;
    cpu_accepts = 1'b0;
    cpu_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (cpu_input_pc_valid && cpu_input_pc_ready) begin
        int pc;
        bit acc_now;
        pc = int'(cpu_input_pc) & 7;
        obs_pc.push_back(int'(cpu_input_pc));
        obs_ch.push_back(int'(current_character));
        acc_now = p_acc[pc] && (current_character == 8'h00);
        cpu_busy = 1'b1;
        @(posedge clk); #1;
        cpu_input_pc_ready = 1'b0;
        repeat (p_lat[pc]) begin @(posedge clk); #1; end
        for (int k = 0; k < p_nout[pc]; k++) begin
          cpu_output_pc_valid = 1'b1;
          cpu_output_pc = p_pc[pc][k];
          cpu_output_pc_is_directed_to_current = p_dir[pc][k];
          if (acc_now && p_merge[pc] && k == p_nout[pc] - 1) begin
            cpu_accepts = 1'b1;
            acc_now = 1'b0;
          end
          @(posedge clk); #1;
          cpu_output_pc_valid = 1'b0;
          cpu_accepts = 1'b0;
        end
        if (acc_now) begin
          cpu_accepts = 1'b1;
          @(posedge clk); #1;
          cpu_accepts = 1'b0;
        end
        @(posedge clk); #1;
        cpu_input_pc_ready = 1'b1;
        cpu_busy = 1'b0;
      end
    end
  end

  // Character source: holds each element valid until taken.
  initial begin
    int my_gen;
    my_gen = 0;
    feed_idx = 0;
    char_in_valid = 1'b0;
    char_in = '0;
    char_in_last = 1'b0;
    forever begin
      @(negedge clk);
      if (s_gen != my_gen) begin
        my_gen = s_gen;
        feed_idx = 0;
      end
      if (feed_idx < s_len) begin
        char_in_valid = 1'b1;
        char_in = s_ch[feed_idx];
        char_in_last = (feed_idx == s_len - 1);
      end else begin
        char_in_valid = 1'b0;
      end
      if (char_in_valid && char_in_ready) begin
        @(posedge clk); #1;
        feed_idx++;
      end
    end
  end

  // Thread-list model of one match.
  task automatic model(output bit m_acc, output bit m_ovf,
                       output int m_cons);
    int unsigned cur [$];
    int unsigned nxt [$];
    exp_pc.delete();
    exp_ch.delete();
    cur.push_back(0);
    m_acc = 0;
    m_ovf = 0;
    m_cons = 0;
    for (int ci = 0; ci < s_len; ci++) begin
      int unsigned ch;
      ch = s_ch[ci];
      m_cons++;
      while (cur.size() > 0) begin
        int unsigned pc;
        pc = cur.pop_front();
        exp_pc.push_back(pc);
        exp_ch.push_back(ch);
        for (int k = 0; k < p_nout[pc]; k++) begin
          if (p_dir[pc][k]) begin
            if (cur.size() < D) cur.push_back(p_pc[pc][k]);
            else m_ovf = 1;
          end else begin
            if (nxt.size() < D) nxt.push_back(p_pc[pc][k]);
            else m_ovf = 1;
          end
        end
        if (p_acc[pc] && ch == 0) begin
          m_acc = 1;
          return;
        end
      end
      if (ci == s_len - 1 || nxt.size() == 0) return;
      cur = nxt;
      nxt.delete();
    end
  endtask

  task automatic clear_prog();
    for (int p = 0; p < 8; p++) begin
      p_nout[p]  = 0;
      p_acc[p]   = 0;
      p_lat[p]   = $urandom_range(0, 2);
      p_merge[p] = $urandom_range(0, 1) == 1;
    end
  endtask

  task automatic rand_prog();
    clear_prog();
    for (int p = 0; p < 8; p++) begin
      p_nout[p] = $urandom_range(0, 2);
      p_acc[p]  = $urandom_range(0, 3) == 0;
      for (int k = 0; k < p_nout[p]; k++) begin
        p_dir[p][k] = (p < 7) && ($urandom_range(0, 1) == 1);
        if (p_dir[p][k]) p_pc[p][k] = 8'($urandom_range(p + 1, 7));
        else             p_pc[p][k] = 8'($urandom_range(0, 7));
      end
    end
    s_len = $urandom_range(1, 4);
    for (int i = 0; i < s_len; i++) begin
      case ($urandom_range(0, 2))
        0:       s_ch[i] = 8'h61;
        1:       s_ch[i] = 8'h62;
        default: s_ch[i] = 8'h00;
      endcase
    end
  endtask

  task automatic wait_cpu_idle();
    int t;
    t = 0;
    while (cpu_busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("cpu_idle", cpu_busy, 0);
  endtask

  task automatic run_trial(input string nm, input int dr_delay);
    bit m_acc;
    bit m_ovf;
    int m_cons;
    int base;
    int nobs;
    int t;
    wait_cpu_idle();
    model(m_acc, m_ovf, m_cons);
    base = obs_pc.size();
    s_gen++;
    @(negedge clk);
    chk({nm, " start_ready"}, start_ready, 1);
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    t = 0;
    while (!done_valid && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({nm, " done_valid"}, done_valid, 1);
    if (!done_valid) begin
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      return;
    end
    chk({nm, " accepted"}, done_accepted, m_acc);
    chk({nm, " overflow"}, overflow, m_ovf);
    chk({nm, " chars"}, feed_idx, m_cons);
    nobs = obs_pc.size() - base;
    chk({nm, " ndisp"}, nobs, exp_pc.size());
    for (int i = 0; i < nobs && i < exp_pc.size(); i++) begin
      chk($sformatf("%s pc[%0d]", nm, i), obs_pc[base + i], exp_pc[i]);
      chk($sformatf("%s ch[%0d]", nm, i), obs_ch[base + i], exp_ch[i]);
    end
    repeat (dr_delay) begin
      @(negedge clk);
      chk({nm, " done_hold"}, {done_valid, done_accepted},
          {1'b1, m_acc});
    end
    @(negedge clk);
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
    @(negedge clk);
    chk({nm, " idle_after"}, {start_ready, done_valid}, 2'b10);
  endtask

  initial begin
    int t;
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t;
    rst = 1'b1;
    start_valid = 1'b0;
    done_ready = 1'b0;
    clear_prog();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset outs",
        {start_ready, char_in_ready, cpu_input_pc_valid,
         cpu_output_pc_ready, done_valid, done_accepted, overflow},
        7'b1000000);
    chk("reset char", current_character, 0);

    // Reset in the middle of RUN after an overflow.
    clear_prog();
    p_nout[0] = 5;
    for (int k = 0; k < 5; k++) begin
      p_pc[0][k] = 8'(k + 1);
      p_dir[0][k] = 0;
    end
    p_lat[0] = 0;
    s_ch[0] = 8'h61;
    s_ch[1] = 8'h62;
    s_len = 2;
    s_gen++;
    @(negedge clk);
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    t = 0;
    while (!overflow && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("midrun ovf", overflow, 1);
    chk("midrun run", cpu_output_pc_ready, 1);
    s_len = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrun rst outs",
        {start_ready, char_in_ready, cpu_input_pc_valid,
         done_valid, overflow},
        5'b10000);
    chk("midrun rst char", current_character, 0);

    // Accept on the terminator after one advance.
    clear_prog();
    p_nout[0] = 1; p_pc[0][0] = 8'd3; p_dir[0][0] = 0;
    p_acc[3] = 1;
    s_ch[0] = 8'h61; s_ch[1] = 8'h00; s_len = 2;
    run_trial("accept", 1);

    // No thread survives the first character.
    clear_prog();
    s_ch[0] = 8'h61; s_ch[1] = 8'h62; s_len = 2;
    run_trial("dead", 0);

    // Current-char thread runs before next-char thread.
    clear_prog();
    p_nout[0] = 2;
    p_pc[0][0] = 8'd5; p_dir[0][0] = 1;
    p_pc[0][1] = 8'd7; p_dir[0][1] = 0;
    s_ch[0] = 8'h61; s_ch[1] = 8'h62; s_len = 2;
    run_trial("order", 0);

    // Five next-char threads into a four-entry queue.
    clear_prog();
    p_nout[0] = 5;
    for (int k = 0; k < 5; k++) begin
      p_pc[0][k] = 8'(k + 1);
      p_dir[0][k] = 0;
    end
    s_ch[0] = 8'h61; s_ch[1] = 8'h62; s_len = 2;
    run_trial("overflow", 0);

    // Last char with pending NXT threads, slow consumer.
    clear_prog();
    p_nout[0] = 1; p_pc[0][0] = 8'd2; p_dir[0][0] = 0;
    s_ch[0] = 8'h61; s_len = 1;
    run_trial("last_nxt", 3);

    for (int n = 0; n < 30; n++) begin
      rand_prog();
      run_trial($sformatf("rand%0d", n), $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
